// File: rtl/ila_capture_core.sv
// Logic-analyser capture engine: circular sample buffer, masked edge/level trigger, pre-trigger retention.
// Optional ILA_TIMESTAMP_EN stores a 32-bit cycle stamp with each sample (read_data = {stamp, sample}).
//
// state  | meaning
// IDLE   | no capture since reset
// PRE    | filling the pre-trigger window, triggers ignored
// WAIT   | circular writes, waiting for trigger
// POST   | filling the rest of the buffer after trigger
// DONE   | capture finished, buffer frozen for readback
module ila_capture_core #(
  parameter int DATA_W   = 32,
  parameter int BUFFER_W = 10,
  parameter int N_TRIG   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   sample_data,
  input  logic [N_TRIG-1:0]   trigger_in,
  input  logic [N_TRIG-1:0]   trig_mask,
  input  logic [N_TRIG-1:0]   trig_edge,
  input  logic [N_TRIG-1:0]   trig_negate,
  input  logic                trig_and,
  input  logic [BUFFER_W-1:0] pretrig_cnt,
  input  logic                arm,
  input  logic                stop,
  input  logic [BUFFER_W-1:0] read_addr,
`ifdef ILA_TIMESTAMP_EN
  output logic [DATA_W+31:0]  read_data,
`else
  output logic [DATA_W-1:0]   read_data,
`endif
  output logic [2:0]          state,
  output logic                triggered,
  output logic [BUFFER_W:0]   n_samples
);
  localparam int DEPTH = 2**BUFFER_W;
`ifdef ILA_TIMESTAMP_EN
  localparam int MEM_W = DATA_W + 32;
`else
  localparam int MEM_W = DATA_W;
`endif
  localparam logic [BUFFER_W:0] FULL = {1'b1, {BUFFER_W{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_WAIT = 3'd2,
    S_POST = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic                trig_q, trig_d;
  logic [BUFFER_W:0]   n_q, n_d, n_inc;
  logic [BUFFER_W-1:0] wptr_q, wptr_d, wptr_inc;
  logic [BUFFER_W-1:0] start_q, start_d;
  logic [BUFFER_W-1:0] pre_q, pre_d;
  logic [BUFFER_W-1:0] rd_idx;
  logic [N_TRIG-1:0]   cond, cprev_q, hit;
  logic                fire, we;
  logic [MEM_W-1:0]    wdata, rdata_q;
  logic [MEM_W-1:0]    mem [DEPTH];

`ifdef ILA_TIMESTAMP_EN
  logic [31:0] ts_q;
  always_ff @(posedge clk) begin
    if (!rst) ts_q <= '0;
    else      ts_q <= ts_q + 32'd1;
  end
  assign wdata = {ts_q, sample_data};
`else
  assign wdata = sample_data;
`endif

  assign cond     = trigger_in ^ trig_negate;
  assign hit      = cond & (~trig_edge | ~cprev_q);
  // Unmasked channels are neutral in either combination; an empty mask never fires.
  assign fire     = (|trig_mask) &&
                    (trig_and ? &(hit | ~trig_mask) : |(hit & trig_mask));
  assign n_inc    = n_q + 1'b1;
  assign wptr_inc = wptr_q + 1'b1;
  assign rd_idx   = start_q + read_addr;

  always_comb begin
    state_d = state_q;
    trig_d  = trig_q;
    n_d     = n_q;
    wptr_d  = wptr_q;
    start_d = start_q;
    pre_d   = pre_q;
    we      = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (arm) begin
          state_d = S_PRE;
          n_d     = '0;
          trig_d  = 1'b0;
          pre_d   = pretrig_cnt;  // field width already bounds it to DEPTH-1
        end
      end
      S_PRE: begin
        if (stop) begin
          state_d = S_DONE;
          start_d = wptr_q - n_q[BUFFER_W-1:0];
        end else if (n_q == {1'b0, pre_q}) begin
          state_d = S_WAIT;
        end else begin
          we     = 1'b1;
          wptr_d = wptr_inc;
          n_d    = n_inc;
          if (n_inc == {1'b0, pre_q}) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (stop) begin
          state_d = S_DONE;
          start_d = wptr_q - n_q[BUFFER_W-1:0];
        end else begin
          we     = 1'b1;
          wptr_d = wptr_inc;
          if (fire) begin
            trig_d  = 1'b1;
            start_d = wptr_q - pre_q;
            n_d     = n_inc;
            state_d = (n_inc == FULL) ? S_DONE : S_POST;
          end
        end
      end
      S_POST: begin
        if (stop) begin
          state_d = S_DONE;
        end else begin
          we     = 1'b1;
          wptr_d = wptr_inc;
          n_d    = n_inc;
          if (n_inc == FULL) state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      trig_q  <= 1'b0;
      n_q     <= '0;
      wptr_q  <= '0;
      start_q <= '0;
      pre_q   <= '0;
      cprev_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      trig_q  <= trig_d;
      n_q     <= n_d;
      wptr_q  <= wptr_d;
      start_q <= start_d;
      pre_q   <= pre_d;
      cprev_q <= cond;
      rdata_q <= mem[rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst && we) mem[wptr_q] <= wdata;
  end

  assign read_data = rdata_q;
  assign state     = state_q;
  assign triggered = trig_q;
  assign n_samples = n_q;

endmodule

// File: tb/tb_ila_capture_core.sv
// Directed bench for ila_capture_core (DATA_W=8, BUFFER_W=4, N_TRIG=4); sample_data tracks the cycle count.
module tb_ila_capture_core;
  localparam int DW = 8;
  localparam int BW = 4;
  localparam int NT = 4;

  logic          clk;
  logic          rst;
  logic [DW-1:0] sample_data;
  logic [NT-1:0] trigger_in, trig_mask, trig_edge, trig_negate;
  logic          trig_and;
  logic [BW-1:0] pretrig_cnt;
  logic          arm, stop;
  logic [BW-1:0] read_addr;
  logic [DW-1:0] read_data;
  logic [2:0]    state;
  logic          triggered;
  logic [BW:0]   n_samples;

  int cyc;
  int checks;
  int passed;

  ila_capture_core #(.DATA_W(DW), .BUFFER_W(BW), .N_TRIG(NT)) dut (
    .clk(clk), .rst(rst), .sample_data(sample_data),
    .trigger_in(trigger_in), .trig_mask(trig_mask), .trig_edge(trig_edge),
    .trig_negate(trig_negate), .trig_and(trig_and), .pretrig_cnt(pretrig_cnt),
    .arm(arm), .stop(stop), .read_addr(read_addr), .read_data(read_data),
    .state(state), .triggered(triggered), .n_samples(n_samples)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  assign sample_data = cyc[7:0];

  task automatic run_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic arm_pulse(output int a);
    arm = 1'b1;
    a = cyc;
    @(negedge clk);
    arm = 1'b0;
  endtask

  task automatic read_idx(input int idx, output logic [DW-1:0] d);
    read_addr = idx[BW-1:0];
    @(negedge clk);
    d = read_data;
  endtask

  task automatic wait_state(input logic [2:0] tgt, input int budget, input string name);
    int n = 0;
    while (state !== tgt && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (state !== tgt) $display("FAIL %s: state %0d after %0d cycles, expected %0d", name, state, n, tgt);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (state !== 3'd0) $display("FAIL rst_state: got %0d expected 0", state); else passed++;
    checks++; if (triggered !== 1'b0) $display("FAIL rst_trig: got %0b expected 0", triggered); else passed++;
    checks++; if (n_samples !== 5'd0) $display("FAIL rst_n: got %0d expected 0", n_samples); else passed++;
    checks++; if (read_data !== 8'd0) $display("FAIL rst_rdata: got %0d expected 0", read_data); else passed++;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_level();
    int a, t;
    logic [DW-1:0] d;
    trig_mask = 4'b0001; trig_edge = 4'b0000; trig_negate = 4'b0000; trig_and = 1'b0;
    pretrig_cnt = 4'd4; trigger_in = 4'b0000;
    @(negedge clk);
    arm_pulse(a);
    checks++; if (state !== 3'd1) $display("FAIL level_pre: state %0d expected 1", state); else passed++;
    t = a + 10;
    run_until(t);
    checks++; if (state !== 3'd2) $display("FAIL level_wait: state %0d expected 2", state); else passed++;
    trigger_in = 4'b0001;
    @(negedge clk);
    checks++; if (state !== 3'd3) $display("FAIL level_post: state %0d expected 3", state); else passed++;
    checks++; if (triggered !== 1'b1) $display("FAIL level_trig: got %0b expected 1", triggered); else passed++;
    wait_state(3'd4, 30, "level_done");
    trigger_in = 4'b0000;
    checks++; if (n_samples !== 5'd16) $display("FAIL level_n: got %0d expected 16", n_samples); else passed++;
    read_idx(0, d);
    checks++; if (d !== 8'(t - 4)) $display("FAIL level_idx0: got %0d expected %0d", d, 8'(t - 4)); else passed++;
    read_idx(3, d);
    checks++; if (d !== 8'(t - 1)) $display("FAIL level_idx3: got %0d expected %0d", d, 8'(t - 1)); else passed++;
    read_idx(4, d);
    checks++; if (d !== 8'(t)) $display("FAIL level_idx4: got %0d expected %0d", d, 8'(t)); else passed++;
    read_idx(15, d);
    checks++; if (d !== 8'(t + 11)) $display("FAIL level_idx15: got %0d expected %0d", d, 8'(t + 11)); else passed++;
  endtask

  task automatic test_edge_negate();
    int a, t;
    logic [DW-1:0] d;
    trig_mask = 4'b0010; trig_edge = 4'b0010; trig_negate = 4'b0010; trig_and = 1'b0;
    pretrig_cnt = 4'd4; trigger_in = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    arm_pulse(a);
    run_until(a + 12);
    checks++; if (state !== 3'd2) $display("FAIL edge_hold_state: got %0d expected 2", state); else passed++;
    checks++; if (triggered !== 1'b0) $display("FAIL edge_hold_trig: got %0b expected 0", triggered); else passed++;
    trigger_in = 4'b0010;
    t = a + 20;
    run_until(t);
    checks++; if (triggered !== 1'b0) $display("FAIL edge_fall_trig: got %0b expected 0", triggered); else passed++;
    trigger_in = 4'b0000;
    @(negedge clk);
    checks++; if (triggered !== 1'b1) $display("FAIL edge_fire: got %0b expected 1", triggered); else passed++;
    wait_state(3'd4, 30, "edge_done");
    read_idx(3, d);
    checks++; if (d !== 8'(t - 1)) $display("FAIL edge_idx3: got %0d expected %0d", d, 8'(t - 1)); else passed++;
    read_idx(4, d);
    checks++; if (d !== 8'(t)) $display("FAIL edge_idx4: got %0d expected %0d", d, 8'(t)); else passed++;
  endtask

  task automatic test_and_mode();
    int a, t;
    logic [DW-1:0] d;
    trig_mask = 4'b0011; trig_edge = 4'b0000; trig_negate = 4'b0000; trig_and = 1'b1;
    pretrig_cnt = 4'd4; trigger_in = 4'b0001;
    @(negedge clk);
    arm_pulse(a);
    run_until(a + 12);
    checks++; if (state !== 3'd2) $display("FAIL and_one_state: got %0d expected 2", state); else passed++;
    checks++; if (triggered !== 1'b0) $display("FAIL and_one_trig: got %0b expected 0", triggered); else passed++;
    t = a + 14;
    run_until(t);
    trigger_in = 4'b0011;
    @(negedge clk);
    checks++; if (triggered !== 1'b1) $display("FAIL and_both_trig: got %0b expected 1", triggered); else passed++;
    wait_state(3'd4, 30, "and_done");
    trigger_in = 4'b0000;
    read_idx(4, d);
    checks++; if (d !== 8'(t)) $display("FAIL and_idx4: got %0d expected %0d", d, 8'(t)); else passed++;

    trig_mask = 4'b0000; trigger_in = 4'b1111; trig_and = 1'b1;
    @(negedge clk);
    arm_pulse(a);
    run_until(a + 20);
    checks++; if (state !== 3'd2 || triggered !== 1'b0)
      $display("FAIL mask0_and: state %0d trig %0b expected 2/0", state, triggered); else passed++;
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    @(negedge clk);
    checks++; if (state !== 3'd2 || n_samples !== 5'd4)
      $display("FAIL arm_in_wait: state %0d n %0d expected 2/4", state, n_samples); else passed++;
    trig_and = 1'b0;
    run_until(a + 30);
    checks++; if (state !== 3'd2 || triggered !== 1'b0)
      $display("FAIL mask0_or: state %0d trig %0b expected 2/0", state, triggered); else passed++;
    arm = 1'b1; stop = 1'b1;
    @(negedge clk);
    arm = 1'b0; stop = 1'b0;
    checks++; if (state !== 3'd4 || n_samples !== 5'd4 || triggered !== 1'b0)
      $display("FAIL wait_stop: state %0d n %0d trig %0b expected 4/4/0", state, n_samples, triggered); else passed++;
    trigger_in = 4'b0000;
  endtask

  task automatic test_stop();
    int a;
    logic [DW-1:0] d;
    trig_mask = 4'b0000; pretrig_cnt = 4'd15; trigger_in = 4'b0000;
    @(negedge clk);
    arm_pulse(a);
    run_until(a + 25);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    checks++; if (state !== 3'd4) $display("FAIL stop_state: got %0d expected 4", state); else passed++;
    checks++; if (triggered !== 1'b0) $display("FAIL stop_trig: got %0b expected 0", triggered); else passed++;
    checks++; if (n_samples !== 5'd15) $display("FAIL stop_n: got %0d expected 15", n_samples); else passed++;
    read_idx(0, d);
    checks++; if (d !== 8'(a + 10)) $display("FAIL stop_idx0: got %0d expected %0d", d, 8'(a + 10)); else passed++;
    read_idx(14, d);
    checks++; if (d !== 8'(a + 24)) $display("FAIL stop_idx14: got %0d expected %0d", d, 8'(a + 24)); else passed++;
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    @(negedge clk);
    checks++; if (state !== 3'd4 || n_samples !== 5'd15)
      $display("FAIL stop_in_done: state %0d n %0d expected 4/15", state, n_samples); else passed++;
  endtask

  task automatic test_reset_mid();
    int a, t;
    logic [DW-1:0] d;
    trig_mask = 4'b0001; trig_edge = 4'b0000; trig_negate = 4'b0000; trig_and = 1'b0;
    pretrig_cnt = 4'd2; trigger_in = 4'b0000;
    @(negedge clk);
    arm_pulse(a);
    run_until(a + 6);
    trigger_in = 4'b0001;
    @(negedge clk);
    trigger_in = 4'b0000;
    @(negedge clk);
    checks++; if (state !== 3'd3) $display("FAIL mid_post: state %0d expected 3", state); else passed++;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (state !== 3'd0 || n_samples !== 5'd0 || triggered !== 1'b0)
      $display("FAIL mid_reset: state %0d n %0d trig %0b expected 0/0/0", state, n_samples, triggered); else passed++;
    rst = 1'b1;
    @(negedge clk);
    arm_pulse(a);
    t = a + 8;
    run_until(t);
    trigger_in = 4'b0001;
    @(negedge clk);
    trigger_in = 4'b0000;
    wait_state(3'd4, 30, "rearm_done");
    checks++; if (triggered !== 1'b1 || n_samples !== 5'd16)
      $display("FAIL rearm_status: trig %0b n %0d expected 1/16", triggered, n_samples); else passed++;
    read_idx(0, d);
    checks++; if (d !== 8'(t - 2)) $display("FAIL rearm_idx0: got %0d expected %0d", d, 8'(t - 2)); else passed++;
    read_idx(2, d);
    checks++; if (d !== 8'(t)) $display("FAIL rearm_idx2: got %0d expected %0d", d, 8'(t)); else passed++;
    read_idx(15, d);
    checks++; if (d !== 8'(t + 13)) $display("FAIL rearm_idx15: got %0d expected %0d", d, 8'(t + 13)); else passed++;
  endtask

  initial begin
    checks = 0; passed = 0;
    rst = 1'b0; arm = 1'b0; stop = 1'b0;
    trigger_in = '0; trig_mask = '0; trig_edge = '0; trig_negate = '0;
    trig_and = 1'b0; pretrig_cnt = '0; read_addr = '0;
    @(negedge clk);
    test_reset();
    test_level();
    test_edge_negate();
    test_and_mode();
    test_stop();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
